// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, results published on HI/LO with a one-cycle done pulse.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] ALUin1,
    input  logic [31:0] ALUin2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [1:0]  opreg;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [4:0]  count;
    logic        negres;
    logic        negrem;

    logic        sgn1, sgn2;
    logic [31:0] mag1, mag2;
    logic [32:0] addsum, shifted, diff;
    logic [63:0] accnext, prod;
    logic [31:0] quo, rmd;

    // op[0]=0 selects the signed flavours, which work on magnitudes
    assign sgn1 = ~op[0] & ALUin1[31];
    assign sgn2 = ~op[0] & ALUin2[31];
    assign mag1 = sgn1 ? -ALUin1 : ALUin1;
    assign mag2 = sgn2 ? -ALUin2 : ALUin2;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        addsum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        shifted = {acc[63:32], acc[31]};
        diff    = shifted - {1'b0, opnd};
        accnext = {addsum, acc[31:1]};
        if (opreg[1]) begin
            if (!diff[32])
                accnext = {diff[31:0], acc[30:0], 1'b1};
            else
                accnext = {shifted[31:0], acc[30:0], 1'b0};
        end
        prod = negres ? -accnext : accnext;
        quo  = negres ? -accnext[31:0] : accnext[31:0];
        rmd  = negrem ? -accnext[63:32] : accnext[63:32];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 5'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            opreg       <= 2'd0;
            opnd        <= 32'd0;
            acc         <= 64'd0;
            negres      <= 1'b0;
            negrem      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opreg       <= op;
                        count       <= 5'd0;
                        negres      <= sgn1 ^ sgn2;
                        negrem      <= sgn1;
                        div_by_zero <= 1'b0;
                        if (op[1] && ALUin2 == 32'd0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            hi          <= ALUin1;
                            lo          <= 32'hFFFF_FFFF;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            opnd  <= op[1] ? mag2 : mag1;
                            acc   <= op[1] ? {32'd0, mag1} : {32'd0, mag2};
                        end
                    end
                end
                CALC: begin
                    acc   <= accnext;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (opreg[1]) begin
                            hi <= rmd;
                            lo <= quo;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] ALUin1, ALUin2;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .ALUin1(ALUin1), .ALUin2(ALUin2), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic; SV division truncates toward zero, remainder follows dividend
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint q, r;
        longint unsigned uq, ur;
        ez = 1'b0;
        eh = 32'd0;
        el = 32'd0;
        if (o[1] && b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else if (o == 2'b00) begin
            q = sa * sb;
            {eh, el} = q;
        end else if (o == 2'b01) begin
            uq = ua * ub;
            {eh, el} = uq;
        end else if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            el = uq[31:0];
            eh = ur[31:0];
        end
    endfunction

    // Caller positions at a negedge; injKind 1 = extra start, 2 = reset, at sample injCycle
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int injKind, input int injCycle);
        logic [31:0] eh, el;
        logic        ez;
        int          cycles, busyCycles;
        model(o, a, b, eh, el, ez);
        start = 1'b1; op = o; ALUin1 = a; ALUin2 = b;
        @(posedge clock); #1;
        start = 1'b0; ALUin1 = $urandom; ALUin2 = $urandom; op = 2'($urandom_range(3, 0));
        cycles = 1;
        busyCycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busyCycles++;
            if (injKind != 0 && cycles == injCycle) begin
                @(negedge clock);
                if (injKind == 1) begin
                    start = 1'b1; op = 2'b11; ALUin1 = 32'h1234_5678; ALUin2 = 32'd0;
                end else begin
                    reset = 1'b1;
                end
            end
            @(posedge clock); #1;
            start = 1'b0;
            cycles++;
            if (injKind == 2 && cycles == injCycle + 1) begin
                checkOutput("abort_busy", 64'(busy), 64'd0);
                checkOutput("abort_done", 64'(done), 64'd0);
                checkOutput("abort_hilo", {hi, lo}, 64'd0);
                return;
            end
        end
        checkOutput("latency", 64'(cycles), (o[1] && b == 32'd0) ? 64'd1 : 64'd33);
        checkOutput("busy_cycles", 64'(busyCycles), (o[1] && b == 32'd0) ? 64'd0 : 64'd32);
        checkOutput("hi", 64'(hi), 64'(eh));
        checkOutput("lo", 64'(lo), 64'(el));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(ez));
        @(posedge clock); #1;
        checkOutput("done_pulse", {62'd0, done, busy}, 64'd0);
        checkOutput("hold", {hi, lo}, {eh, el});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b1; op = 2'b01; ALUin1 = 32'd5; ALUin2 = 32'd9;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);

        @(negedge clock); reset = 1'b0; start = 1'b0;
        @(negedge clock); applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        @(negedge clock); applyStimulus(2'b00, -32'sd3, 32'd7, 0, 0);
        @(negedge clock); applyStimulus(2'b10, -32'sd7, 32'd2, 0, 0);
        @(negedge clock); applyStimulus(2'b11, 32'd100, 32'd0, 0, 0);
        @(negedge clock); applyStimulus(2'b11, 32'd100, 32'd7, 0, 0);
        @(negedge clock); applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        @(negedge clock); applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
        @(negedge clock); applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 10);
        @(negedge clock); applyStimulus(2'b10, 32'hFEDC_BA98, 32'd3, 2, 15);

        // Start presented on the very edge where reset drops
        @(negedge clock); reset = 1'b0;
        applyStimulus(2'b01, 32'd6, 32'd7, 0, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(3, 0));
            ra = $urandom;
            rb = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
            if (i % 5 == 1) rb = 32'($urandom_range(15, 1));
            @(negedge clock); applyStimulus(ro, ra, rb, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- ALUin1  input  32  first operand (multiplicand or dividend).
- ALUin2  input  32  second operand (multiplier or divisor), taken from the ALUsrc operand mux output.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- hi  output  32  HI register: product[63:32] or remainder.
- lo  output  32  LO register: product[31:0] or quotient.
- div_by_zero  output  1  flag set when the last completed operation was a division by zero.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-005 IDLE with start=1 SHALL, on that edge:
- latch op and the operand magnitudes (signed ops take the absolute value; unsigned ops take the raw value);
- latch the result sign flags;
- clear the 5-bit iteration counter;
- go to CALC.
REQ-006 IDLE with start=0 SHALL remain in IDLE with no register changes.
REQ-007 start SHALL be ignored while in CALC or DONE; there SHALL be no queuing.
REQ-008 CALC SHALL perform exactly one iteration per cycle:
- multiply: radix-2 shift-add, 64-bit accumulator;
- divide: restoring shift-subtract, 32-bit remainder and 32-bit quotient.
REQ-009 CALC SHALL last exactly 32 cycles. On the edge with counter=31 it SHALL go to DONE and load hi and lo with the sign-corrected result on the same edge.
REQ-010 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E32. hi and lo SHALL be valid from that cycle.
REQ-011 busy SHALL equal (state==CALC). done SHALL equal (state==DONE). DONE SHALL return to IDLE on the next edge unconditionally.
REQ-012 MULT/MULTU SHALL set {hi,lo} to the exact 64-bit signed or unsigned product. The signed product SHALL be negated when the operand signs differ.
REQ-013 DIV/DIVU SHALL set lo to the quotient, truncated toward zero, and hi to the remainder. The remainder sign SHALL equal the dividend sign.
REQ-014 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-015 DIV/DIVU with ALUin2=0 at acceptance SHALL:
- go directly from IDLE to DONE, with latency 1 (done high the cycle after E0);
- set hi=ALUin1, lo=0xFFFFFFFF and div_by_zero=1.
REQ-016 div_by_zero SHALL be cleared on acceptance of any subsequent operation.
REQ-017 hi, lo and div_by_zero SHALL hold their values from one completion to the next. Operand inputs SHALL be don't-care after the acceptance edge.

Reset
REQ-018 While reset=1 at an edge, the block SHALL set:
- state=IDLE and counter=0;
- hi=0, lo=0;
- busy=0, done=0, div_by_zero=0.
REQ-019 Reset SHALL take priority over start.
REQ-020 Reset asserted in CALC or DONE SHALL abort the operation: no done pulse, hi and lo cleared.
REQ-021 A start present on the first edge after reset deasserts SHALL be accepted.

Verification
REQ-022 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done after 33 edges; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
REQ-023 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-024 DIVU 100 / 0 -> done the cycle after start; hi=100, lo=0xFFFFFFFF, div_by_zero=1. A following DIVU 100 / 7 -> lo=14, hi=2, div_by_zero=0.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-026 start pulsed again in CALC at cycle 10 -> ignored; exactly one done pulse; result matches the first operation.
REQ-027 reset asserted in CALC at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse; a new MULTU 6 x 7 then gives lo=42, hi=0.
